m_dmem_responder: RTL and testbench

//   Target-side data memory for the pipelined core: accepts load/store requests over a

---
 rtl/m_dmem_pkg.sv | 21 ++
 rtl/m_sram_1rw.sv | 37 +++
 rtl/m_dmem_responder.sv | 130 +++++++++++++
 tb/tb_m_dmem_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, response error
// code, default geometry and the latched request record.
package m_dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic RSP_ERR = 1'b1;

  localparam int DEFAULT_DEPTH_WORDS = 1024;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

endpackage

// File: rtl/m_sram_1rw.sv
// Single-port 32-bit memory with byte-enabled synchronous write and registered read.
// Each byte lane is its own array so every lane maps onto a plain block RAM column.
module m_sram_1rw #(
  parameter int DEPTH = 1024
) (
  input  logic                     w_clk,
  input  logic                     w_en,
  input  logic                     w_we,
  input  logic [3:0]               w_be,
  input  logic [$clog2(DEPTH)-1:0] w_addr,
  input  logic [31:0]              w_wdata,
  output logic [31:0]              w_rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rdata_reg;

      always_ff @(posedge w_clk) begin
        if (w_en) begin
          if (w_we) begin
            if (w_be[gi]) begin
              lane_mem[w_addr] <= w_wdata[8*gi +: 8];
            end
          end else begin
            lane_rdata_reg <= lane_mem[w_addr];
          end
        end
      end

      assign w_rdata[8*gi +: 8] = lane_rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/m_dmem_responder.sv
// Target-side data memory: one outstanding load/store over valid/ready, answered after
// WAIT_CYCLES extra cycles, with out-of-range addresses flagged instead of aliased.
module m_dmem_responder
  import m_dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int          WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_req_valid,
  output logic        w_req_ready,
  input  logic        w_req_we,
  input  logic [31:0] w_req_addr,
  input  logic [31:0] w_req_wdata,
  input  logic [3:0]  w_req_be,
  output logic        w_rsp_valid,
  input  logic        w_rsp_ready,
  output logic [31:0] w_rsp_rdata,
  output logic        w_rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS) << 2;
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]    state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          rsp_err_reg, rsp_load_reg;
  logic          accept, access_fire, in_range;
  dmem_req_t     req_live, acc_req;
  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic [31:0]   sram_rdata;

  assign w_req_ready = (state_reg == ST_IDLE);
  assign accept      = w_req_valid & w_req_ready;
  assign req_live    = '{we: w_req_we, addr: w_req_addr, wdata: w_req_wdata, be: w_req_be};

  // Without a wait the access happens on the accept edge from the live bus,
  // which is what lets a zero-wait build turn a request around every two cycles.
  generate
    if (ZERO_WAIT) begin : g_direct
      assign acc_req     = req_live;
      assign access_fire = accept;
    end else begin : g_waited
      dmem_req_t req_reg;

      always_ff @(posedge w_clk) begin
        if (accept) begin
          req_reg <= req_live;
        end
      end

      assign acc_req     = req_reg;
      assign access_fire = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);
    end
  endgenerate

  // Addresses below BASE_ADDR wrap to a huge offset and fail the same compare.
  assign offset   = acc_req.addr - BASE_ADDR;
  assign in_range = (offset < SPAN);
  assign word_idx = offset[AW+1:2];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (ZERO_WAIT) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_RESP: begin
        if (w_rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      rsp_err_reg  <= 1'b0;
      rsp_load_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (access_fire) begin
        rsp_err_reg  <= in_range ? ~RSP_ERR : RSP_ERR;
        rsp_load_reg <= in_range & ~acc_req.we;
      end
    end
  end

  m_sram_1rw #(
    .DEPTH (DEPTH_WORDS)
  ) u_sram (
    .w_clk   (w_clk),
    .w_en    (access_fire & in_range),
    .w_we    (acc_req.we),
    .w_be    (acc_req.be),
    .w_addr  (word_idx),
    .w_wdata (acc_req.wdata),
    .w_rdata (sram_rdata)
  );

  // The RAM output register is untouched during RESP, so gated data stays stable.
  assign w_rsp_valid = (state_reg == ST_RESP);
  assign w_rsp_err   = w_rsp_valid & rsp_err_reg;
  assign w_rsp_rdata = (w_rsp_valid & rsp_load_reg) ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_m_dmem_responder.sv
// Scoreboard bench: a WAIT_CYCLES=2 instance for functional/timing cases and a
// WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_m_dmem_responder;

  logic w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  logic w_rst_n;
  int   cyc = 0;
  always @(posedge w_clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;
  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_be;

  m_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n),
    .w_req_valid(a_req_valid), .w_req_ready(a_req_ready), .w_req_we(a_req_we),
    .w_req_addr(a_req_addr), .w_req_wdata(a_req_wdata), .w_req_be(a_req_be),
    .w_rsp_valid(a_rsp_valid), .w_rsp_ready(a_rsp_ready),
    .w_rsp_rdata(a_rsp_rdata), .w_rsp_err(a_rsp_err)
  );

  m_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .w_clk(w_clk), .w_rst_n(w_rst_n),
    .w_req_valid(z_req_valid), .w_req_ready(z_req_ready), .w_req_we(z_req_we),
    .w_req_addr(z_req_addr), .w_req_wdata(z_req_wdata), .w_req_be(z_req_be),
    .w_rsp_valid(z_rsp_valid), .w_rsp_ready(z_rsp_ready),
    .w_rsp_rdata(z_rsp_rdata), .w_rsp_err(z_rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          lat;
    bit          gap;
  } exp_t;

  exp_t qa[$];
  exp_t qz[$];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor for the waited instance: latency on first sight, data/err on handshake.
  initial begin
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge w_clk);
      if (!w_rst_n) begin
        seen = 1'b0;
      end else if (a_rsp_valid) begin
        if (qa.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL A_unexpected_rsp: got rsp_valid=1 want no response pending");
        end else begin
          if (!seen) begin
            seen = 1'b1;
            if (qa[0].lat >= 0) check32("A_latency", cyc - qa[0].acc_cyc, qa[0].lat);
          end
          if (a_rsp_ready) begin
            check32("A_rdata", a_rsp_rdata, qa[0].rdata);
            check32("A_err", {31'h0, a_rsp_err}, {31'h0, qa[0].err});
            void'(qa.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Monitor for the zero-wait instance: data/err and handshake spacing.
  initial begin
    int last_hs;
    last_hs = -100;
    forever begin
      @(negedge w_clk);
      if (w_rst_n && z_rsp_valid) begin
        if (qz.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL Z_unexpected_rsp: got rsp_valid=1 want no response pending");
        end else if (z_rsp_ready) begin
          check32("Z_rdata", z_rsp_rdata, qz[0].rdata);
          check32("Z_err", {31'h0, z_rsp_err}, {31'h0, qz[0].err});
          if (qz[0].gap) check32("Z_gap", cyc - last_hs, 2);
          last_hs = cyc;
          void'(qz.pop_front());
        end
      end
    end
  end

  // Called just after a rising edge; returns the edge count at which the request was taken.
  task automatic a_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                       output int acc);
    bit   r;
    int   n;
    exp_t e;
    n   = 0;
    acc = -1;
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_be    = be;
    while (acc < 0 && n < 100) begin
      r = a_req_ready;
      @(posedge w_clk);
      #1;
      n++;
      if (r) acc = cyc;
    end
    a_req_valid = 1'b0;
    if (acc < 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL A_accept_timeout: got no accept want accept for addr %h", addr);
    end else begin
      e = '{rdata: exp_rd, err: exp_err, acc_cyc: acc, lat: 3, gap: 1'b0};
      qa.push_back(e);
    end
  endtask

  task automatic a_drain();
    int n;
    n = 0;
    while (qa.size() > 0 && n < 100) begin
      @(posedge w_clk);
      #1;
      n++;
    end
  endtask

  task automatic a_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err);
    int acc;
    a_req(we, addr, wdata, be, exp_rd, exp_err, acc);
    a_drain();
    $display("[TB] A we=%0d addr=%h wdata=%h be=%b accepted@%0d exp_rdata=%h exp_err=%0d",
             we, addr, wdata, be, acc, exp_rd, exp_err);
  endtask

  logic        z_we_t [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] z_ad_t [6] = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8};
  logic [31:0] z_wd_t [6] = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 32'h0, 32'h0, 32'h0};
  logic [31:0] z_rd_t [6] = '{32'h0, 32'h0, 32'h0, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2};

  initial begin
    int   acc, c, n, k;
    bit   r;
    exp_t e;

    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0;
    a_rsp_ready = 1;
    z_req_valid = 0; z_req_we = 0; z_req_addr = 0; z_req_wdata = 0; z_req_be = 0;
    z_rsp_ready = 1;
    w_rst_n = 1'b0;
    repeat (3) @(posedge w_clk);
    #1;
    w_rst_n = 1'b1;

    check32("reset_req_ready", {31'h0, a_req_ready}, 32'h1);
    check32("reset_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
    check32("reset_rsp_rdata", a_rsp_rdata, 32'h0);
    check32("reset_rsp_err", {31'h0, a_rsp_err}, 32'h0);

    // Full store, read back, then partial and no-op stores on the same word.
    a_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
    a_txn(1'b0, 32'h10, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0);
    a_txn(1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 32'h0, 1'b0);
    a_txn(1'b0, 32'h10, 32'h0,         4'b0000, 32'hDEAD_AAEF, 1'b0);
    a_txn(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    a_txn(1'b0, 32'h10, 32'h0,         4'b0000, 32'hDEAD_AAEF, 1'b0);

    // Range edges: one past the end errors, a store there must not alias word 4.
    a_txn(1'b0, 32'h1000, 32'h0,         4'b0000, 32'h0, 1'b1);
    a_txn(1'b1, 32'h1010, 32'h5555_5555, 4'b1111, 32'h0, 1'b1);
    a_txn(1'b0, 32'h10,   32'h0,         4'b0000, 32'hDEAD_AAEF, 1'b0);
    a_txn(1'b1, 32'hFFC,  32'h0BAD_F00D, 4'b1111, 32'h0, 1'b0);
    a_txn(1'b0, 32'hFFF,  32'h0,         4'b0000, 32'h0BAD_F00D, 1'b0);

    // Reset while a store is still waiting: it must be discarded.
    a_txn(1'b1, 32'h20, 32'h1111_1111, 4'b1111, 32'h0, 1'b0);
    a_req(1'b1, 32'h20, 32'h2222_2222, 4'b1111, 32'h0, 1'b0, acc);
    w_rst_n = 1'b0;
    qa.delete();
    @(negedge w_clk);
    check32("midwait_reset_req_ready", {31'h0, a_req_ready}, 32'h1);
    check32("midwait_reset_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
    check32("midwait_reset_rsp_rdata", a_rsp_rdata, 32'h0);
    check32("midwait_reset_rsp_err", {31'h0, a_rsp_err}, 32'h0);
    $display("[TB] A reset asserted mid-WAIT after accept@%0d", acc);
    @(posedge w_clk);
    #1;
    w_rst_n = 1'b1;
    a_txn(1'b0, 32'h20, 32'h0, 4'b0000, 32'h1111_1111, 1'b0);

    // Back-pressure with a second request parked on the bus.
    a_rsp_ready = 1'b0;
    a_req(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEAD_AAEF, 1'b0, acc);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h24;
    a_req_wdata = 32'h0F0F_0F0F; a_req_be = 4'b1111;
    n = 0;
    while (!a_rsp_valid && n < 20) begin
      @(posedge w_clk);
      #1;
      n++;
    end
    check32("hold_rsp_seen", {31'h0, a_rsp_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge w_clk);
      #1;
      check32("hold_rsp_valid", {31'h0, a_rsp_valid}, 32'h1);
      check32("hold_rsp_rdata", a_rsp_rdata, 32'hDEAD_AAEF);
      check32("hold_req_ready", {31'h0, a_req_ready}, 32'h0);
    end
    a_rsp_ready = 1'b1;
    c = cyc;
    a_req(1'b1, 32'h24, 32'h0F0F_0F0F, 4'b1111, 32'h0, 1'b0, acc);
    check32("accept_after_handshake", acc, c + 2);
    $display("[TB] A held load released@%0d, parked store accepted@%0d", c + 1, acc);
    a_drain();
    a_txn(1'b0, 32'h24, 32'h0, 4'b0000, 32'h0F0F_0F0F, 1'b0);

    // Zero-wait instance: three stores then three loads, valid never dropped.
    k = 0;
    n = 0;
    z_req_valid = 1'b1;
    z_req_we = z_we_t[0]; z_req_addr = z_ad_t[0]; z_req_wdata = z_wd_t[0]; z_req_be = 4'b1111;
    while (k < 6 && n < 200) begin
      r = z_req_ready;
      @(posedge w_clk);
      #1;
      n++;
      if (r) begin
        e = '{rdata: z_rd_t[k], err: 1'b0, acc_cyc: cyc, lat: -1, gap: (k > 0)};
        qz.push_back(e);
        $display("[TB] Z we=%0d addr=%h wdata=%h accepted@%0d exp_rdata=%h",
                 z_we_t[k], z_ad_t[k], z_wd_t[k], cyc, z_rd_t[k]);
        k++;
        if (k < 6) begin
          z_req_we = z_we_t[k]; z_req_addr = z_ad_t[k]; z_req_wdata = z_wd_t[k];
        end else begin
          z_req_valid = 1'b0;
        end
      end
    end
    check32("Z_all_accepted", k, 6);

    n = 0;
    while ((qa.size() > 0 || qz.size() > 0) && n < 100) begin
      @(posedge w_clk);
      #1;
      n++;
    end
    check32("A_queue_drained", qa.size(), 0);
    check32("Z_queue_drained", qz.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
